// File: rtl/pmem_pkg.sv
// Shared types and constants for the cacheline-to-burst memory adaptor.
package pmem_pkg;

  localparam int PMEM_LINE_WIDTH  = 256;
  localparam int PMEM_BEAT_WIDTH  = 64;
  localparam int PMEM_BEATS       = PMEM_LINE_WIDTH / PMEM_BEAT_WIDTH;
  localparam int PMEM_OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } pmem_adapt_state_t;

  // Clear the byte-within-line offset so bursts always start on a line boundary.
  function automatic logic [31:0] pmem_line_align(input logic [31:0] addr);
    return addr & ~((32'd1 << PMEM_OFFSET_BITS) - 32'd1);
  endfunction

endpackage

// File: rtl/pmem_line_adaptor_if.sv
// Arbiter-side line request signals and DRAM-side burst signals of the adaptor.
interface pmem_line_adaptor_if;
  import pmem_pkg::*;

  logic                       ab_pmem_read;
  logic                       ab_pmem_write;
  logic [31:0]                ab_pmem_address;
  logic [PMEM_LINE_WIDTH-1:0] ab_pmem_wdata;
  logic [PMEM_LINE_WIDTH-1:0] ab_pmem_rdata;
  logic                       ab_pmem_resp;

  logic                       mem_read;
  logic                       mem_write;
  logic [31:0]                mem_address;
  logic [PMEM_BEAT_WIDTH-1:0] mem_wdata;
  logic [PMEM_BEAT_WIDTH-1:0] mem_rdata;
  logic                       mem_resp;

  // The adaptor is the slave of the arbiter and drives the memory burst.
  modport slave (
    input  ab_pmem_read, ab_pmem_write, ab_pmem_address, ab_pmem_wdata,
    input  mem_rdata, mem_resp,
    output ab_pmem_rdata, ab_pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output ab_pmem_read, ab_pmem_write, ab_pmem_address, ab_pmem_wdata,
    output mem_rdata, mem_resp,
    input  ab_pmem_rdata, ab_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/line_shift_buffer.sv
// Line register: whole-line capture for writes, per-beat fill for reads,
// and beat selection for the outgoing write burst.
module line_shift_buffer
  import pmem_pkg::*;
#(
  parameter int  LINE_WIDTH = PMEM_LINE_WIDTH,
  parameter int  BEAT_WIDTH = PMEM_BEAT_WIDTH,
  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH,
  localparam int IDX_BITS   = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load_line_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic                  load_beat_i,
  input  logic [IDX_BITS-1:0]   beat_idx_i,
  input  logic [BEAT_WIDTH-1:0] beat_i,
  input  logic [IDX_BITS-1:0]   sel_idx_i,
  output logic [BEAT_WIDTH-1:0] beat_o,
  output logic [LINE_WIDTH-1:0] line_next_o
);

  logic [LINE_WIDTH-1:0] line_q;

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    logic [BEAT_WIDTH-1:0] slot_d;

    always_comb begin
      slot_d = line_q[gi*BEAT_WIDTH +: BEAT_WIDTH];
      if (load_line_i) begin
        slot_d = line_i[gi*BEAT_WIDTH +: BEAT_WIDTH];
      end else if (load_beat_i && (beat_idx_i == IDX_BITS'(gi))) begin
        slot_d = beat_i;
      end
    end

    assign line_next_o[gi*BEAT_WIDTH +: BEAT_WIDTH] = slot_d;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      line_q <= '0;
    end else begin
      line_q <= line_next_o;
    end
  end

  assign beat_o = line_q[sel_idx_i*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/pmem_line_adaptor.sv
// Turns one cacheline read/write request into a 4-beat burst on the memory
// port and pulses ab_pmem_resp once the whole line has moved.
module pmem_line_adaptor
  import pmem_pkg::*;
#(
  parameter int  LINE_WIDTH = PMEM_LINE_WIDTH,
  parameter int  BEAT_WIDTH = PMEM_BEAT_WIDTH,
  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH
) (
  input logic               clk,
  input logic               reset,
  pmem_line_adaptor_if.slave bus
);

  localparam int CNT_BITS = $clog2(BEATS);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  pmem_adapt_state_t     state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] rdata_q;

  logic                  load_line;
  logic                  load_beat;
  logic                  rdata_load;
  logic [BEAT_WIDTH-1:0] cur_beat;
  logic [LINE_WIDTH-1:0] line_next;

  line_shift_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_line_buf (
    .clk         (clk),
    .srst        (reset),
    .load_line_i (load_line),
    .line_i      (bus.ab_pmem_wdata),
    .load_beat_i (load_beat),
    .beat_idx_i  (cnt_q),
    .beat_i      (bus.mem_rdata),
    .sel_idx_i   (cnt_q),
    .beat_o      (cur_beat),
    .line_next_o (line_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (rdata_load) begin
        rdata_q <= line_next;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    load_line  = 1'b0;
    load_beat  = 1'b0;
    rdata_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.ab_pmem_write) begin
          addr_d    = pmem_line_align(bus.ab_pmem_address);
          load_line = 1'b1;
          state_d   = WRITE;
        end else if (bus.ab_pmem_read) begin
          addr_d  = pmem_line_align(bus.ab_pmem_address);
          state_d = READ;
        end
      end
      READ: begin
        if (bus.mem_resp) begin
          load_beat = 1'b1;
          // The final beat is merged on its way into the visible read register.
          if (cnt_q == LAST_BEAT) begin
            rdata_load = 1'b1;
            state_d    = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (bus.mem_resp) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read      = (state_q == READ);
    bus.mem_write     = (state_q == WRITE);
    bus.mem_address   = addr_q;
    bus.mem_wdata     = (state_q == WRITE) ? cur_beat : '0;
    bus.ab_pmem_resp  = (state_q == DONE);
    bus.ab_pmem_rdata = rdata_q;
  end

endmodule

// File: tb/tb_pmem_line_adaptor.sv
// Scenario and randomized checks of pmem_line_adaptor against a line-level model.
module tb_pmem_line_adaptor;
  import pmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pmem_line_adaptor_if bus();

  pmem_line_adaptor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [255:0] model_rdata = '0;

  int           obs_cycles, obs_rd_cycles, obs_wr_cycles, obs_both;
  int           obs_resp_early, obs_addr_changes, obs_wdata_slips, stim_gaps;
  logic [31:0]  obs_addr;
  logic [255:0] obs_wline;
  logic         obs_resp_end;
  logic [255:0] obs_rdata_end;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Acts as the DRAM for one burst: request must already be driven; the first
  // tick is the accept edge. Leaves the bench in the DONE cycle.
  task automatic run_burst(input logic [255:0] rline, input int gap_min,
                           input int gap_max, input int change_at);
    int gap;
    logic ack, last_ack;
    logic [63:0] last_w;
    tick();
    obs_cycles = 0; obs_rd_cycles = 0; obs_wr_cycles = 0; obs_both = 0;
    obs_resp_early = 0; obs_addr_changes = 0; obs_wdata_slips = 0; stim_gaps = 0;
    obs_wline = '0;
    obs_addr = bus.mem_address;
    last_w   = bus.mem_wdata;
    last_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == change_at) begin
        bus.ab_pmem_address = 32'h0000_0200;
        bus.ab_pmem_read    = 1'b0;
        bus.ab_pmem_write   = 1'b0;
        bus.ab_pmem_wdata   = ~bus.ab_pmem_wdata;
      end
      gap = $urandom_range(gap_max, gap_min);
      stim_gaps += gap;
      for (int g = 0; g <= gap; g++) begin
        ack = (g == gap);
        if (bus.mem_read) obs_rd_cycles++;
        if (bus.mem_write) obs_wr_cycles++;
        if (bus.mem_read && bus.mem_write) obs_both++;
        if (bus.ab_pmem_resp) obs_resp_early++;
        if (bus.mem_address !== obs_addr) obs_addr_changes++;
        if (!last_ack && bus.mem_wdata !== last_w) obs_wdata_slips++;
        last_w   = bus.mem_wdata;
        last_ack = ack;
        bus.mem_resp  = ack;
        bus.mem_rdata = ack ? rline[64*k +: 64] : {$urandom, $urandom};
        if (ack) obs_wline[64*k +: 64] = bus.mem_wdata;
        tick();
        obs_cycles++;
      end
    end
    bus.mem_resp  = 1'b0;
    obs_resp_end  = bus.ab_pmem_resp;
    obs_rdata_end = bus.ab_pmem_rdata;
    $display("txn addr=%h rd_cycles=%0d wr_cycles=%0d cycles=%0d resp=%b",
             obs_addr, obs_rd_cycles, obs_wr_cycles, obs_cycles, obs_resp_end);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++;
    if ({bus.ab_pmem_resp, bus.mem_read, bus.mem_write} !== 3'b000)
      $display("FAIL reset_ctrl: got %b expected 000", {bus.ab_pmem_resp, bus.mem_read, bus.mem_write});
    else n_pass++;
    n_checks++;
    if ({bus.mem_address, bus.mem_wdata} !== 96'd0)
      $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", bus.mem_address, bus.mem_wdata);
    else n_pass++;
    n_checks++;
    if (bus.ab_pmem_rdata !== 256'd0)
      $display("FAIL reset_rdata: got %h expected 0", bus.ab_pmem_rdata);
    else n_pass++;
  endtask

  task automatic test_zero_gap_read();
    logic [255:0] line;
    line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    bus.ab_pmem_read = 1'b1;
    bus.ab_pmem_address = 32'h0000_1234;
    run_burst(line, 0, 0, -1);
    bus.ab_pmem_read = 1'b0;
    model_rdata = line;
    n_checks++;
    if (obs_addr !== 32'h0000_1220) $display("FAIL zg_addr: got %h expected 00001220", obs_addr);
    else n_pass++;
    n_checks++;
    if (obs_cycles != 4 || obs_resp_end !== 1'b1 || obs_resp_early != 0)
      $display("FAIL zg_latency: got cycles %0d resp %b early %0d expected 4 1 0", obs_cycles, obs_resp_end, obs_resp_early);
    else n_pass++;
    n_checks++;
    if (obs_rdata_end !== line) $display("FAIL zg_rdata: got %h expected %h", obs_rdata_end, line);
    else n_pass++;
    n_checks++;
    if (obs_rd_cycles != 4 || obs_wr_cycles != 0)
      $display("FAIL zg_mem_read: got rd %0d wr %0d expected 4 0", obs_rd_cycles, obs_wr_cycles);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.ab_pmem_resp !== 1'b0) $display("FAIL zg_resp_pulse: got %b expected 0", bus.ab_pmem_resp);
    else n_pass++;
  endtask

  task automatic test_write_gaps();
    logic [255:0] d;
    d = rand_line();
    bus.ab_pmem_write = 1'b1;
    bus.ab_pmem_address = 32'h0000_8040;
    bus.ab_pmem_wdata = d;
    run_burst(rand_line(), 2, 2, -1);
    bus.ab_pmem_write = 1'b0;
    n_checks++;
    if (obs_addr !== 32'h0000_8040) $display("FAIL wg_addr: got %h expected 00008040", obs_addr);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs_wline[64*k +: 64] !== d[64*k +: 64])
        $display("FAIL wg_beat%0d: got %h expected %h", k, obs_wline[64*k +: 64], d[64*k +: 64]);
      else n_pass++;
    end
    n_checks++;
    if (obs_wdata_slips != 0) $display("FAIL wg_step_on_ack: got %0d slips expected 0", obs_wdata_slips);
    else n_pass++;
    n_checks++;
    if (obs_wr_cycles != 12 || obs_rd_cycles != 0 || obs_cycles != 12)
      $display("FAIL wg_held: got wr %0d rd %0d cycles %0d expected 12 0 12", obs_wr_cycles, obs_rd_cycles, obs_cycles);
    else n_pass++;
    n_checks++;
    if (obs_resp_end !== 1'b1 || obs_resp_early != 0 || obs_rdata_end !== model_rdata)
      $display("FAIL wg_resp: got resp %b early %0d rdata %h expected 1 0 %h", obs_resp_end, obs_resp_early, obs_rdata_end, model_rdata);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.ab_pmem_resp !== 1'b0) $display("FAIL wg_resp_pulse: got %b expected 0", bus.ab_pmem_resp);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [255:0] d;
    d = rand_line();
    bus.ab_pmem_read = 1'b1;
    bus.ab_pmem_write = 1'b1;
    bus.ab_pmem_address = $urandom;
    bus.ab_pmem_wdata = d;
    run_burst(rand_line(), 0, 1, -1);
    bus.ab_pmem_read = 1'b0;
    bus.ab_pmem_write = 1'b0;
    n_checks++;
    if (obs_rd_cycles != 0 || obs_wr_cycles != obs_cycles)
      $display("FAIL sim_write_wins: got rd %0d wr %0d expected 0 %0d", obs_rd_cycles, obs_wr_cycles, obs_cycles);
    else n_pass++;
    n_checks++;
    if (obs_wline !== d) $display("FAIL sim_wdata: got %h expected %h", obs_wline, d);
    else n_pass++;
    tick();
  endtask

  task automatic test_mid_change();
    logic [255:0] line;
    line = rand_line();
    bus.ab_pmem_read = 1'b1;
    bus.ab_pmem_address = 32'h0000_0100;
    run_burst(line, 0, 1, 2);
    model_rdata = line;
    n_checks++;
    if (obs_addr !== 32'h0000_0100 || obs_addr_changes != 0)
      $display("FAIL mid_addr: got %h changes %0d expected 00000100 0", obs_addr, obs_addr_changes);
    else n_pass++;
    n_checks++;
    if (obs_resp_end !== 1'b1 || obs_rdata_end !== line || obs_rd_cycles != obs_cycles)
      $display("FAIL mid_complete: got resp %b rdata %h expected 1 %h", obs_resp_end, obs_rdata_end, line);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if ({bus.ab_pmem_resp, bus.mem_read, bus.mem_write} !== 3'b000)
      $display("FAIL mid_after: got %b expected 000", {bus.ab_pmem_resp, bus.mem_read, bus.mem_write});
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] line;
    bus.ab_pmem_read = 1'b1;
    bus.ab_pmem_address = 32'h0000_0440;
    tick();
    bus.mem_resp = 1'b1;
    bus.mem_rdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    reset = 1'b1;
    bus.ab_pmem_read = 1'b0;
    bus.mem_rdata = 64'hDEAD_BEEF_0000_0002;
    tick();
    reset = 1'b0;
    bus.mem_resp = 1'b0;
    model_rdata = '0;
    n_checks++;
    if ({bus.ab_pmem_resp, bus.mem_read, bus.mem_write} !== 3'b000 ||
        bus.mem_address !== 32'd0 || bus.mem_wdata !== 64'd0 || bus.ab_pmem_rdata !== 256'd0)
      $display("FAIL rst_mid_outputs: got ctrl %b addr %h wdata %h rdata %h expected all 0",
               {bus.ab_pmem_resp, bus.mem_read, bus.mem_write}, bus.mem_address, bus.mem_wdata, bus.ab_pmem_rdata);
    else n_pass++;
    bus.mem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.ab_pmem_resp, bus.mem_read, bus.mem_write} !== 3'b000)
        $display("FAIL rst_idle_ack_ignored: got %b expected 000", {bus.ab_pmem_resp, bus.mem_read, bus.mem_write});
      else n_pass++;
    end
    bus.mem_resp = 1'b0;
    line = rand_line();
    bus.ab_pmem_read = 1'b1;
    bus.ab_pmem_address = 32'h0000_0300;
    run_burst(line, 0, 2, -1);
    bus.ab_pmem_read = 1'b0;
    model_rdata = line;
    n_checks++;
    if (obs_addr !== 32'h0000_0300 || obs_rdata_end !== line || obs_resp_end !== 1'b1 || obs_cycles != 4 + stim_gaps)
      $display("FAIL rst_then_read: got addr %h rdata %h resp %b cycles %0d expected 00000300 %h 1 %0d",
               obs_addr, obs_rdata_end, obs_resp_end, obs_cycles, line, 4 + stim_gaps);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [255:0] line;
    line = rand_line();
    bus.ab_pmem_read = 1'b1;
    bus.ab_pmem_address = $urandom;
    run_burst(line, 0, 1, -1);
    model_rdata = line;
    n_checks++;
    if (obs_resp_end !== 1'b1 || obs_rdata_end !== line)
      $display("FAIL b2b_read: got resp %b rdata %h expected 1 %h", obs_resp_end, obs_rdata_end, line);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.ab_pmem_resp, bus.mem_read, bus.mem_write} !== 3'b000)
      $display("FAIL b2b_no_reaccept: got %b expected 000", {bus.ab_pmem_resp, bus.mem_read, bus.mem_write});
    else n_pass++;
    bus.ab_pmem_read = 1'b0;
    bus.ab_pmem_write = 1'b1;
    bus.ab_pmem_wdata = rand_line();
    run_burst(rand_line(), 0, 1, -1);
    bus.ab_pmem_write = 1'b0;
    n_checks++;
    if (obs_wr_cycles != obs_cycles || obs_rd_cycles != 0 || obs_resp_end !== 1'b1)
      $display("FAIL b2b_write: got wr %0d rd %0d resp %b expected %0d 0 1", obs_wr_cycles, obs_rd_cycles, obs_resp_end, obs_cycles);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.ab_pmem_rdata !== line) $display("FAIL b2b_rdata_kept: got %h expected %h", bus.ab_pmem_rdata, line);
    else n_pass++;
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] addr;
    logic [255:0] wline, rline, exp_rdata;
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(2, 0);
      addr = $urandom;
      wline = rand_line();
      rline = rand_line();
      bus.ab_pmem_read = (kind != 1);
      bus.ab_pmem_write = (kind != 0);
      bus.ab_pmem_address = addr;
      bus.ab_pmem_wdata = wline;
      run_burst(rline, 0, 3, -1);
      bus.ab_pmem_read = 1'b0;
      bus.ab_pmem_write = 1'b0;
      exp_rdata = (kind != 0) ? model_rdata : rline;
      model_rdata = exp_rdata;
      n_checks++;
      if (obs_addr !== {addr[31:5], 5'd0} || obs_addr_changes != 0)
        $display("FAIL rnd%0d_addr: got %h expected %h", t, obs_addr, {addr[31:5], 5'd0});
      else n_pass++;
      n_checks++;
      if (obs_cycles != 4 + stim_gaps || obs_resp_end !== 1'b1 || obs_resp_early != 0)
        $display("FAIL rnd%0d_latency: got cycles %0d resp %b expected %0d 1", t, obs_cycles, obs_resp_end, 4 + stim_gaps);
      else n_pass++;
      n_checks++;
      if (obs_both != 0 || obs_rd_cycles != ((kind == 0) ? obs_cycles : 0) || obs_wr_cycles != ((kind != 0) ? obs_cycles : 0))
        $display("FAIL rnd%0d_type: got rd %0d wr %0d both %0d kind %0d", t, obs_rd_cycles, obs_wr_cycles, obs_both, kind);
      else n_pass++;
      n_checks++;
      if (obs_rdata_end !== exp_rdata) $display("FAIL rnd%0d_rdata: got %h expected %h", t, obs_rdata_end, exp_rdata);
      else n_pass++;
      if (kind != 0) begin
        n_checks++;
        if (obs_wline !== wline || obs_wdata_slips != 0)
          $display("FAIL rnd%0d_wdata: got %h slips %0d expected %h", t, obs_wline, obs_wdata_slips, wline);
        else n_pass++;
      end
      bus.mem_resp = $urandom_range(1, 0);
      tick();
      bus.mem_resp = 1'b0;
      n_checks++;
      if (bus.ab_pmem_resp !== 1'b0) $display("FAIL rnd%0d_resp_pulse: got %b expected 0", t, bus.ab_pmem_resp);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.ab_pmem_read = 1'b0;
    bus.ab_pmem_write = 1'b0;
    bus.ab_pmem_address = '0;
    bus.ab_pmem_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_resp = 1'b0;
    test_reset();
    test_zero_gap_read();
    test_write_gaps();
    test_simultaneous();
    test_mid_change();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
